lc3b_mem_responder: RTL

- Memory-side responder for the LC-3b multicycle core.
- Answers the core's mem_read/mem_write requests on the mem_address/mem_wdata/mem_rdata bus, using a mem_resp handshake after a programmable latency.
- Backed by an internal word array; supports byte-enabled stores.
- Used as the memory model in the core testbench and as the on-chip RAM in small builds.

---
 rtl/lc3b_mem_responder.sv | 136 +++++++++++++
 1 files changed

// File: rtl/lc3b_mem_responder.sv
// LC-3b memory responder: word array answering mem_read/mem_write; MEM_RANDOM_LATENCY_EN enables LFSR-varied latency.
// Latency: mem_resp pulses LATENCY cycles after acceptance (or min(lfsr[3:0]+1, LATENCY) with the macro).
// Backpressure: one transaction in flight; requests are only sampled in IDLE, next acceptance is the cycle after mem_resp.
module lc3b_mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_resp
);

    localparam logic [4:0] LAT5 = 5'(LATENCY);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                 state;
    logic [4:0]             count;
    logic                   op_write;
    logic [ADDR_BITS-1:0]   idx_q;
    logic [15:0]            wdata_q;
    logic [1:0]             be_q;
    logic [15:0]            mem [0:(1<<ADDR_BITS)-1];

    logic                   req;
    logic [ADDR_BITS-1:0]   idx_in;
    logic [4:0]             eff_lat;
    logic                   commit;
    logic                   c_write;
    logic [ADDR_BITS-1:0]   c_idx;
    logic [15:0]            c_wdata;
    logic [1:0]             c_be;
    logic                   unused_addr;

    assign req         = mem_read | mem_write;
    assign idx_in      = mem_address[ADDR_BITS:1];
    assign unused_addr = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

`ifdef MEM_RANDOM_LATENCY_EN
    logic [15:0] lfsr;
    logic [4:0]  lfsr_lat;

    assign lfsr_lat = {1'b0, lfsr[3:0]} + 5'd1;
    assign eff_lat  = (lfsr_lat < LAT5) ? lfsr_lat : LAT5;

    // Advances once per accepted request; the pre-advance value sets that request's latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else if (state == IDLE && req) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end
`else
    assign eff_lat = LAT5;
`endif

    // Commit happens on the edge entering RESP; with latency 1 that is the acceptance edge itself.
    always_comb begin
        commit  = 1'b0;
        c_write = op_write;
        c_idx   = idx_q;
        c_wdata = wdata_q;
        c_be    = be_q;
        if (!rst) begin
            if (state == IDLE && req && eff_lat == 5'd1) begin
                commit  = 1'b1;
                c_write = mem_write;
                c_idx   = idx_in;
                c_wdata = mem_wdata;
                c_be    = mem_byte_enable;
            end else if (state == BUSY && count == 5'd0) begin
                commit  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit && c_write) begin
            if (c_be[0]) mem[c_idx][7:0]  <= c_wdata[7:0];
            if (c_be[1]) mem[c_idx][15:8] <= c_wdata[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 5'd0;
            mem_resp  <= 1'b0;
            mem_rdata <= 16'h0000;
            op_write  <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= 16'h0000;
            be_q      <= 2'b00;
        end else begin
            mem_resp <= 1'b0;
            if (commit && !c_write) begin
                mem_rdata <= mem[c_idx];
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        op_write <= mem_write;
                        idx_q    <= idx_in;
                        wdata_q  <= mem_wdata;
                        be_q     <= mem_byte_enable;
                        if (eff_lat == 5'd1) begin
                            state    <= RESP;
                            mem_resp <= 1'b1;
                        end else begin
                            state <= BUSY;
                            count <= eff_lat - 5'd2;
                        end
                    end
                end
                BUSY: begin
                    if (count == 5'd0) begin
                        state    <= RESP;
                        mem_resp <= 1'b1;
                    end else begin
                        count <= count - 5'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
